// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Execute controller that owns the accumulator and sequences a
//               shared 8-bit ALU, including shift-and-add MUL.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int WIDTH          = 8,
    parameter bit MUL_EARLY_EXIT = 1'b0
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             instr_valid_in,
    output logic             instr_ready_out,
    input  logic [3:0]       opcode_in,
    input  logic [WIDTH-1:0] operand_in,
    output logic [2:0]       alu_unit_sel_out,
    output logic             alu_op_sel_out,
    output logic [WIDTH-1:0] alu_acc_out,
    output logic [WIDTH-1:0] alu_src_out,
    input  logic [WIDTH-1:0] alu_res_in,
    output logic [WIDTH-1:0] acc_out,
    output logic             zero_out,
    output logic             done_out
);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_EXEC    = 3'd1;
    localparam logic [2:0] c_S_MUL_ADD = 3'd2;
    localparam logic [2:0] c_S_MUL_SHL = 3'd3;
    localparam logic [2:0] c_S_WB      = 3'd4;

    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_SUB = 4'd1;
    localparam logic [3:0] c_OP_SHL = 4'd2;
    localparam logic [3:0] c_OP_SHR = 4'd3;
    localparam logic [3:0] c_OP_LDI = 4'd4;
    localparam logic [3:0] c_OP_OR  = 4'd5;
    localparam logic [3:0] c_OP_XOR = 4'd6;
    localparam logic [3:0] c_OP_AND = 4'd7;
    localparam logic [3:0] c_OP_MUL = 4'd8;

    localparam logic [2:0] c_U_ADD  = 3'b000;
    localparam logic [2:0] c_U_SHF  = 3'b010;
    localparam logic [2:0] c_U_PASS = 3'b011;
    localparam logic [2:0] c_U_OR   = 3'b100;
    localparam logic [2:0] c_U_XOR  = 3'b101;
    localparam logic [2:0] c_U_AND  = 3'b110;
    localparam logic [2:0] c_U_NONE = 3'b111;

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [3:0]       r_opcode;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_q;
    logic [2:0]       r_cnt;
    logic             r_done;

    logic             w_accept;
    logic [WIDTH-1:0] w_q_next;
    logic             w_mul_last;

    assign instr_ready_out = (r_state == c_S_IDLE);
    assign w_accept        = instr_valid_in & instr_ready_out;
    assign w_q_next        = r_q >> 1;
    // Early exit is legal once no multiplier bits remain: further adds are no-ops.
    assign w_mul_last      = (r_cnt == 3'd7) || (MUL_EARLY_EXIT && (w_q_next == '0));

    assign acc_out  = r_acc;
    assign zero_out = (r_acc == '0);
    assign done_out = r_done;

    always_comb begin
        alu_unit_sel_out = c_U_NONE;
        alu_op_sel_out   = 1'b0;
        alu_acc_out      = r_acc;
        alu_src_out      = '0;
        case (r_state)
            c_S_EXEC: begin
                alu_src_out = r_operand;
                case (r_opcode)
                    c_OP_ADD: alu_unit_sel_out = c_U_ADD;
                    c_OP_SUB: begin
                        alu_unit_sel_out = c_U_ADD;
                        alu_op_sel_out   = 1'b1;
                    end
                    c_OP_SHL: alu_unit_sel_out = c_U_SHF;
                    c_OP_SHR: begin
                        alu_unit_sel_out = c_U_SHF;
                        alu_op_sel_out   = 1'b1;
                    end
                    c_OP_LDI: alu_unit_sel_out = c_U_PASS;
                    c_OP_OR:  alu_unit_sel_out = c_U_OR;
                    c_OP_XOR: alu_unit_sel_out = c_U_XOR;
                    c_OP_AND: alu_unit_sel_out = c_U_AND;
                    default:  alu_unit_sel_out = c_U_NONE;
                endcase
            end
            c_S_MUL_ADD: begin
                alu_unit_sel_out = c_U_ADD;
                alu_acc_out      = r_p;
                alu_src_out      = r_m;
            end
            c_S_MUL_SHL: begin
                alu_unit_sel_out = c_U_SHF;
                alu_acc_out      = r_m;
                alu_src_out      = c_ONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= c_S_IDLE;
            r_opcode  <= '0;
            r_operand <= '0;
            r_acc     <= '0;
            r_p       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_opcode  <= opcode_in;
                        r_operand <= operand_in;
                        if (opcode_in == c_OP_MUL) begin
                            r_p     <= '0;
                            r_m     <= r_acc;
                            r_q     <= operand_in;
                            r_cnt   <= '0;
                            r_state <= c_S_MUL_ADD;
                        end else begin
                            r_state <= c_S_EXEC;
                        end
                    end
                end
                c_S_EXEC: begin
                    r_acc   <= alu_res_in;
                    r_done  <= 1'b1;
                    r_state <= c_S_IDLE;
                end
                c_S_MUL_ADD: begin
                    if (r_q[0]) begin
                        r_p <= alu_res_in;
                    end
                    r_state <= c_S_MUL_SHL;
                end
                c_S_MUL_SHL: begin
                    r_m     <= alu_res_in;
                    r_q     <= w_q_next;
                    r_cnt   <= r_cnt + 3'd1;
                    r_state <= w_mul_last ? c_S_WB : c_S_MUL_ADD;
                end
                c_S_WB: begin
                    r_acc   <= r_p;
                    r_done  <= 1'b1;
                    r_state <= c_S_IDLE;
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Scoreboard bench for alu_sequencer (full-loop and early-exit MUL).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    typedef struct {
        logic [7:0] acc;
        int         lat;
        int         acyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] m_acc[2];

    logic       v0, v1, rdy0, rdy1, os0, os1, z0, z1, dn0, dn1;
    logic [3:0] op0, op1;
    logic [2:0] us0, us1;
    logic [7:0] opd0, opd1, a0, a1, b0, b1, r0, r1, acc0, acc1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_model(input logic [2:0] u, input logic o,
                                             input logic [7:0] a, input logic [7:0] b);
        case (u)
            3'b000:  return o ? a - b : a + b;
            3'b010:  return o ? a >> b[2:0] : a << b[2:0];
            3'b011:  return b;
            3'b100:  return a | b;
            3'b101:  return a ^ b;
            3'b110:  return a & b;
            default: return a;
        endcase
    endfunction

    assign r0 = alu_model(us0, os0, a0, b0);
    assign r1 = alu_model(us1, os1, a1, b1);

    alu_sequencer #(.WIDTH(8), .MUL_EARLY_EXIT(1'b0)) u_dut0 (
        .clk_in(clk), .rst_n_in(rst_n),
        .instr_valid_in(v0), .instr_ready_out(rdy0),
        .opcode_in(op0), .operand_in(opd0),
        .alu_unit_sel_out(us0), .alu_op_sel_out(os0),
        .alu_acc_out(a0), .alu_src_out(b0), .alu_res_in(r0),
        .acc_out(acc0), .zero_out(z0), .done_out(dn0)
    );

    alu_sequencer #(.WIDTH(8), .MUL_EARLY_EXIT(1'b1)) u_dut1 (
        .clk_in(clk), .rst_n_in(rst_n),
        .instr_valid_in(v1), .instr_ready_out(rdy1),
        .opcode_in(op1), .operand_in(opd1),
        .alu_unit_sel_out(us1), .alu_op_sel_out(os1),
        .alu_acc_out(a1), .alu_src_out(b1), .alu_res_in(r1),
        .acc_out(acc1), .zero_out(z1), .done_out(dn1)
    );

    // Architectural result of one instruction, straight from the opcode table.
    function automatic logic [7:0] ref_op(input logic [7:0] acc, input logic [3:0] op,
                                          input logic [7:0] opd);
        logic [15:0] prod;
        prod = 16'(acc) * 16'(opd);
        case (op)
            4'd0:    return acc + opd;
            4'd1:    return acc - opd;
            4'd2:    return acc << opd[2:0];
            4'd3:    return acc >> opd[2:0];
            4'd4:    return opd;
            4'd5:    return acc | opd;
            4'd6:    return acc ^ opd;
            4'd7:    return acc & opd;
            4'd8:    return prod[7:0];
            default: return acc;
        endcase
    endfunction

    // Cycles from the accept edge to the writeback edge.
    function automatic int ref_lat(input logic [3:0] op, input logic [7:0] opd, input bit ee);
        int n;
        if (op != 4'd8) return 1;
        if (!ee) return 17;
        n = 8;
        for (int k = 1; k <= 8; k++) begin
            if ((opd >> k) == 8'd0) begin
                n = k;
                break;
            end
        end
        return 2 * n + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic issue(input int d, input logic [3:0] op, input logic [7:0] opd);
        exp_t e;
        int   n;
        @(negedge clk);
        if (d == 0) begin v0 = 1'b1; op0 = op; opd0 = opd; end
        else        begin v1 = 1'b1; op1 = op; opd1 = opd; end
        n = 0;
        while (!((d == 0) ? rdy0 : rdy1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: dut%0d ready stuck low", d);
        end else begin
            @(posedge clk);
            m_acc[d] = ref_op(m_acc[d], op, opd);
            e.acc  = m_acc[d];
            e.lat  = ref_lat(op, opd, d == 1);
            e.acyc = cyc;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        #1;
        if (d == 0) begin v0 = 1'b0; op0 = 4'($urandom); opd0 = 8'($urandom); end
        else        begin v1 = 1'b0; op1 = 4'($urandom); opd1 = 8'($urandom); end
    endtask

    task automatic mon(input int d, input logic done, input logic ready,
                       input logic zero, input logic [7:0] acc);
        exp_t e;
        int   qs;
        qs = (d == 0) ? q0.size() : q1.size();
        if (done) begin
            if (qs == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: dut%0d acc=%0h", d, acc);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("acc_dut%0d", d), 32'(acc), 32'(e.acc));
                chk($sformatf("latency_dut%0d", d), 32'(cyc - e.acyc), 32'(e.lat + 1));
                chk($sformatf("zero_dut%0d", d), 32'(zero), 32'(e.acc == 8'd0));
                chk($sformatf("ready_at_done_dut%0d", d), 32'(ready), 32'd1);
            end
        end else begin
            chk($sformatf("ready_vs_busy_dut%0d", d), 32'(ready), 32'(qs == 0));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, dn0, rdy0, z0, acc0);
            mon(1, dn1, rdy1, z1, acc1);
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: q0=%0d q1=%0d outstanding", q0.size(), q1.size());
        end
    endtask

    task automatic rand_issue(input int d);
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) op = 4'd8;
        if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        issue(d, op, 8'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        v0 = 1'b0; op0 = '0; opd0 = '0;
        v1 = 1'b0; op1 = '0; opd1 = '0;
        m_acc[0] = 8'd0;
        m_acc[1] = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(rdy0), 32'd1);
        chk("reset_acc", 32'(acc0), 32'd0);
        chk("reset_zero", 32'(z0), 32'd1);
        chk("reset_done", 32'(dn0), 32'd0);
        chk("reset_acc_dut1", 32'(acc1), 32'd0);
        rst_n = 1'b1;

        issue(0, 4'd4, 8'h03);
        issue(0, 4'd0, 8'h05);
        issue(0, 4'd1, 8'h0A);
        drain();
        chk("sub_wrap", 32'(acc0), 32'h0FE);

        issue(0, 4'd4, 8'h80);
        issue(0, 4'd3, 8'h0B);
        issue(0, 4'd2, 8'h04);
        drain();
        chk("shl_to_zero", 32'(acc0), 32'h000);
        chk("shl_zero_flag", 32'(z0), 32'd1);

        issue(0, 4'd4, 8'h03);
        issue(0, 4'd8, 8'h05);
        issue(0, 4'd0, 8'h01);
        drain();
        chk("mul_then_held_add", 32'(acc0), 32'h010);

        issue(0, 4'd4, 8'hC8);
        issue(0, 4'd8, 8'h03);
        drain();
        chk("mul_wrap", 32'(acc0), 32'h058);

        issue(1, 4'd4, 8'h07);
        issue(1, 4'd8, 8'h02);
        drain();
        chk("mul_early_exit", 32'(acc1), 32'h00E);
        issue(1, 4'd12, 8'h5A);
        drain();
        chk("nop_keeps_acc", 32'(acc1), 32'h00E);

        fork
            begin
                for (int i = 0; i < 120; i++) rand_issue(0);
            end
            begin
                for (int j = 0; j < 120; j++) rand_issue(1);
            end
        join
        drain();

        issue(0, 4'd4, 8'h09);
        issue(0, 4'd8, 8'h07);
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        m_acc[0] = 8'd0;
        m_acc[1] = 8'd0;
        #1;
        chk("async_reset_ready", 32'(rdy0), 32'd1);
        chk("async_reset_acc", 32'(acc0), 32'd0);
        chk("async_reset_zero", 32'(z0), 32'd1);
        @(posedge clk);
        #1;
        chk("async_reset_no_done", 32'(dn0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(0, 4'd0, 8'h21);
        drain();
        chk("after_reset_add", 32'(acc0), 32'h021);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
